// File: rtl/phys_reg_release_queue_pkg.sv
// Shared sizing, types and lane-compaction helpers for the commit-side
// physical-register release queue.
package phys_reg_release_queue_pkg;

   localparam int DISPATCH_WIDTH       = 2;
   localparam int PHYS_REGS_ADDR_WIDTH = 6;
   localparam int RELEASE_QUEUE_DEPTH  = 8;

   localparam int QUEUE_PTR_WIDTH   = $clog2(RELEASE_QUEUE_DEPTH);
   localparam int QUEUE_COUNT_WIDTH = $clog2(RELEASE_QUEUE_DEPTH + 1);
   localparam int LANE_COUNT_WIDTH  = $clog2(DISPATCH_WIDTH + 1);

   typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_reg_t;
   typedef logic [QUEUE_PTR_WIDTH-1:0]      queue_ptr_t;
   typedef logic [QUEUE_COUNT_WIDTH-1:0]    queue_count_t;
   typedef logic [LANE_COUNT_WIDTH-1:0]     lane_count_t;
   typedef lane_count_t [DISPATCH_WIDTH-1:0] lane_offsets_t;

   // Write offset of each lane = number of accepted lanes below it.
   function automatic lane_offsets_t prefix_offsets(input logic [DISPATCH_WIDTH-1:0] accept);
      lane_offsets_t offs;
      lane_count_t   running;
      running = '0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         offs[i] = running;
         running = running + lane_count_t'(accept[i]);
      end
      return offs;
   endfunction

   function automatic lane_count_t count_accepted(input logic [DISPATCH_WIDTH-1:0] accept);
      lane_count_t total;
      total = '0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         total = total + lane_count_t'(accept[i]);
      end
      return total;
   endfunction

endpackage

// File: rtl/phys_reg_release_queue.sv
// Buffers physical registers released at commit and drains them, oldest first,
// into the free list push ports whenever the free list is not full.
module phys_reg_release_queue
   import phys_reg_release_queue_pkg::*;
(
   input  logic                                clk,
   input  logic                                rst,
   input  logic [PHYS_REGS_ADDR_WIDTH-1:0]     commit_reg [0:DISPATCH_WIDTH-1],
   input  logic                                commit_en  [0:DISPATCH_WIDTH-1],
   output logic                                commit_ready,
   output logic [PHYS_REGS_ADDR_WIDTH-1:0]     push_reg   [0:DISPATCH_WIDTH-1],
   output logic                                push_en    [0:DISPATCH_WIDTH-1],
   input  logic                                freelist_full,
   output logic [QUEUE_COUNT_WIDTH-1:0]        count
);

   phys_reg_t     entries [0:RELEASE_QUEUE_DEPTH-1];
   queue_ptr_t    head;
   queue_ptr_t    tail;
   logic [DISPATCH_WIDTH-1:0] accept;
   lane_offsets_t write_offs;
   lane_count_t   num_accepted;
   lane_count_t   num_dequeued;

   // Ready looks only at registered occupancy, so a same-cycle drain never opens the gate.
   always_comb begin
      commit_ready = (queue_count_t'(RELEASE_QUEUE_DEPTH) - count) >= queue_count_t'(DISPATCH_WIDTH);
   end

   always_comb begin
      accept = '0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         accept[i] = commit_en[i] && commit_ready && (commit_reg[i] != '0);
      end
      write_offs   = prefix_offsets(accept);
      num_accepted = count_accepted(accept);
   end

   always_comb begin
      num_dequeued = '0;
      if (!freelist_full) begin
         if (count < queue_count_t'(DISPATCH_WIDTH)) begin
            num_dequeued = lane_count_t'(count);
         end else begin
            num_dequeued = lane_count_t'(DISPATCH_WIDTH);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         push_en[i]  = 1'b0;
         push_reg[i] = '0;
         if (lane_count_t'(i) < num_dequeued) begin
            push_en[i]  = 1'b1;
            push_reg[i] = entries[head + queue_ptr_t'(i)];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + queue_ptr_t'(num_dequeued);
         tail  <= tail + queue_ptr_t'(num_accepted);
         count <= count + queue_count_t'(num_accepted) - queue_count_t'(num_dequeued);
      end
   end

   // Payload storage needs no reset; validity is carried entirely by the pointers and count.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         if (rst && accept[i]) begin
            entries[tail + queue_ptr_t'(write_offs[i])] <= commit_reg[i];
         end
      end
   end

endmodule

// File: tb/tb_phys_reg_release_queue.sv
// Directed bench for the release queue; a scoreboard queue holds registers
// accepted but not yet pushed and supplies the expected push values.
module tb_phys_reg_release_queue;
   import phys_reg_release_queue_pkg::*;

   logic                            clk = 1'b0;
   logic                            rst;
   logic [PHYS_REGS_ADDR_WIDTH-1:0] commit_reg [0:DISPATCH_WIDTH-1];
   logic                            commit_en  [0:DISPATCH_WIDTH-1];
   logic                            commit_ready;
   logic [PHYS_REGS_ADDR_WIDTH-1:0] push_reg   [0:DISPATCH_WIDTH-1];
   logic                            push_en    [0:DISPATCH_WIDTH-1];
   logic                            freelist_full;
   logic [QUEUE_COUNT_WIDTH-1:0]    count;

   int test_count = 0;
   int fail_count = 0;
   int scoreboard[$];

   phys_reg_release_queue dut (
      .clk          (clk),
      .rst          (rst),
      .commit_reg   (commit_reg),
      .commit_en    (commit_en),
      .commit_ready (commit_ready),
      .push_reg     (push_reg),
      .push_en      (push_en),
      .freelist_full(freelist_full),
      .count        (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      test_count++;
      assert (observed === expected) else begin
         fail_count++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   function automatic int expected_pushes();
      if (freelist_full) return 0;
      return (scoreboard.size() < DISPATCH_WIDTH) ? scoreboard.size() : DISPATCH_WIDTH;
   endfunction

   task automatic checkOutput();
      int n;
      n = expected_pushes();
      check("count", count, scoreboard.size());
      check("commit_ready", commit_ready, (RELEASE_QUEUE_DEPTH - scoreboard.size()) >= DISPATCH_WIDTH);
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         check($sformatf("push_en[%0d]", i), push_en[i], i < n);
         check($sformatf("push_reg[%0d]", i), push_reg[i], (i < n) ? scoreboard[i] : 0);
      end
   endtask

   // Drives one cycle from a negedge, checks outputs, then advances the model across the posedge.
   task automatic applyStimulus(input int r0, input int r1, input bit e0, input bit e1, input bit ff);
      bit ready;
      int n;
      commit_reg[0] = PHYS_REGS_ADDR_WIDTH'(r0);
      commit_reg[1] = PHYS_REGS_ADDR_WIDTH'(r1);
      commit_en[0]  = e0;
      commit_en[1]  = e1;
      freelist_full = ff;
      #1;
      checkOutput();
      ready = (RELEASE_QUEUE_DEPTH - scoreboard.size()) >= DISPATCH_WIDTH;
      n = expected_pushes();
      repeat (n) void'(scoreboard.pop_front());
      if (ready) begin
         if (e0 && r0 != 0) scoreboard.push_back(r0);
         if (e1 && r1 != 0) scoreboard.push_back(r1);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input bit ff);
      applyStimulus(0, 0, 1'b0, 1'b0, ff);
   endtask

   initial begin
      rst = 1'b0;
      commit_reg[0] = '0;
      commit_reg[1] = '0;
      commit_en[0]  = 1'b0;
      commit_en[1]  = 1'b0;
      freelist_full = 1'b0;
      #1;
      check("reset_count", count, 0);
      check("reset_ready", commit_ready, 1);
      check("reset_push_en0", push_en[0], 0);
      check("reset_push_en1", push_en[1], 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Wrap: move head/tail to 6, then straddle indices 6,7,0,1.
      applyStimulus(1, 2, 1, 1, 1);
      applyStimulus(3, 4, 1, 1, 1);
      applyStimulus(5, 6, 1, 1, 1);
      idle(0);
      idle(0);
      idle(0);
      applyStimulus(20, 21, 1, 1, 1);
      applyStimulus(22, 23, 1, 1, 1);
      freelist_full = 1'b0;
      #1;
      check("wrap_first_reg0", push_reg[0], 20);
      check("wrap_first_reg1", push_reg[1], 21);
      idle(0);
      check("wrap_second_reg0", push_reg[0], 22);
      check("wrap_second_reg1", push_reg[1], 23);
      idle(0);
      idle(0);

      // Single group appears exactly one cycle later.
      applyStimulus(12, 7, 1, 1, 0);
      check("single_reg0", push_reg[0], 12);
      check("single_reg1", push_reg[1], 7);
      check("single_en1", push_en[1], 1);
      idle(0);
      check("single_drained", count, 0);

      // Register 0 dropped, survivors compacted; disabled lane ignored.
      applyStimulus(0, 9, 1, 1, 0);
      check("zero_drop_reg0", push_reg[0], 9);
      check("zero_drop_en1", push_en[1], 0);
      applyStimulus(15, 11, 0, 1, 0);
      check("lane_off_reg0", push_reg[0], 11);
      idle(0);

      // Backpressure fill to full, ignored group, then drain in order.
      applyStimulus(1, 2, 1, 1, 1);
      applyStimulus(3, 4, 1, 1, 1);
      applyStimulus(5, 6, 1, 1, 1);
      check("bp_count6", count, 6);
      check("bp_ready6", commit_ready, 1);
      applyStimulus(7, 8, 1, 1, 1);
      check("bp_count8", count, 8);
      check("bp_ready8", commit_ready, 0);
      applyStimulus(9, 10, 1, 1, 0);
      check("bp_ignored_count", count, 6);
      check("bp_second_reg0", push_reg[0], 3);
      idle(0);
      idle(0);
      idle(0);
      idle(0);

      // Steady state with enqueue and dequeue in the same cycle.
      applyStimulus(30, 31, 1, 1, 1);
      applyStimulus(32, 33, 1, 1, 0);
      applyStimulus(34, 35, 1, 1, 0);
      applyStimulus(36, 37, 1, 1, 0);
      check("steady_count", count, 2);
      idle(0);
      idle(0);

      // Asynchronous reset with five entries buffered.
      applyStimulus(1, 2, 1, 1, 1);
      applyStimulus(3, 4, 1, 1, 1);
      applyStimulus(5, 0, 1, 1, 1);
      check("pre_reset_count", count, 5);
      commit_en[0]  = 1'b0;
      commit_en[1]  = 1'b0;
      freelist_full = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      scoreboard.delete();
      check("mid_reset_count", count, 0);
      check("mid_reset_ready", commit_ready, 1);
      check("mid_reset_en0", push_en[0], 0);
      check("mid_reset_en1", push_en[1], 0);
      check("mid_reset_reg0", push_reg[0], 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(40, 41, 1, 1, 0);
      check("post_reset_reg0", push_reg[0], 40);
      check("post_reset_reg1", push_reg[1], 41);
      idle(0);
      idle(0);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
